// File: rtl/fp_mult_pipe.sv
// Pipelined IEEE-754 multiplier, parametrised widths and depth, valid/ready flow control.
// Subnormal inputs flush to zero; overflow/underflow saturate according to the rounding mode.
module fp_mult_pipe #(
   parameter int unsigned EXP_W   = 8,
   parameter int unsigned MAN_W   = 23,
   parameter int unsigned LATENCY = 3,
   parameter int unsigned TAG_W   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic [2:0]           rnd,
   input  logic [TAG_W-1:0]     tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] z,
   output logic [7:0]           status,
   output logic [TAG_W-1:0]     tag_out
);

   localparam int unsigned EW = EXP_W + 2;
   localparam int unsigned PW = 2 * MAN_W + 2;
   localparam int unsigned MR = MAN_W + 2;
   localparam logic [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 2);

   localparam logic [2:0] RND_NEAR = 3'd0;
   localparam logic [2:0] RND_ZERO = 3'd1;
   localparam logic [2:0] RND_PINF = 3'd2;
   localparam logic [2:0] RND_NINF = 3'd3;
   localparam logic [2:0] RND_UP   = 3'd4;
   localparam logic [2:0] RND_AWAY = 3'd5;

   typedef struct packed {
      logic             valid;
      logic             sign;
      logic [EW-1:0]    exp;
      logic [PW-1:0]    prod;
      logic             is_nan;
      logic             is_inf;
      logic             is_zero;
      logic [2:0]       rnd;
      logic [TAG_W-1:0] tag;
   } s1_t;

   typedef struct packed {
      logic             valid;
      logic             sign;
      logic [EW-1:0]    exp;
      logic [MAN_W:0]   mant;
      logic             guard;
      logic             sticky;
      logic             is_nan;
      logic             is_inf;
      logic             is_zero;
      logic [2:0]       rnd;
      logic [TAG_W-1:0] tag;
   } s2_t;

   typedef struct packed {
      logic             valid;
      logic             sign;
      logic [EW-1:0]    exp;
      logic [MAN_W-1:0] frac;
      logic             inexact;
      logic             is_nan;
      logic             is_inf;
      logic             is_zero;
      logic [2:0]       rnd;
      logic [TAG_W-1:0] tag;
   } s3_t;

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // S1: unpack, classify, mantissa product
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   s1_t              s1_d, s1_q;

   assign ea     = a[EXP_W+MAN_W-1:MAN_W];
   assign eb     = b[EXP_W+MAN_W-1:MAN_W];
   assign fa     = a[MAN_W-1:0];
   assign fb     = b[MAN_W-1:0];
   assign a_zero = ~|ea;
   assign b_zero = ~|eb;
   assign a_inf  = (&ea) & ~|fa;
   assign b_inf  = (&eb) & ~|fb;
   assign a_nan  = (&ea) & |fa;
   assign b_nan  = (&eb) & |fb;

   always_comb begin
      s1_d         = '0;
      s1_d.valid   = in_valid;
      s1_d.sign    = a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
      s1_d.exp     = {2'b00, ea} + {2'b00, eb} - BIAS;
      s1_d.prod    = {{(MAN_W+1){1'b0}}, 1'b1, fa} * {{(MAN_W+1){1'b0}}, 1'b1, fb};
      s1_d.is_nan  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
      s1_d.is_inf  = !s1_d.is_nan & (a_inf | b_inf);
      s1_d.is_zero = !s1_d.is_nan & !s1_d.is_inf & (a_zero | b_zero);
      // Reserved codes behave as round-to-nearest-even
      s1_d.rnd     = (rnd > RND_AWAY) ? RND_NEAR : rnd;
      s1_d.tag     = tag;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     s1_q <= '0;
      else if (adv) s1_q <= s1_d;
   end

   // S2: normalise, guard/sticky
   logic [PW-1:0] prod_n;
   s2_t           s2_d, s2_x;

   always_comb begin
      prod_n       = s1_q.prod[PW-1] ? s1_q.prod : (s1_q.prod << 1);
      s2_d.valid   = s1_q.valid;
      s2_d.sign    = s1_q.sign;
      s2_d.exp     = s1_q.exp + EW'(s1_q.prod[PW-1]);
      s2_d.mant    = prod_n[PW-1:MAN_W+1];
      s2_d.guard   = prod_n[MAN_W];
      s2_d.sticky  = |prod_n[MAN_W-1:0];
      s2_d.is_nan  = s1_q.is_nan;
      s2_d.is_inf  = s1_q.is_inf;
      s2_d.is_zero = s1_q.is_zero;
      s2_d.rnd     = s1_q.rnd;
      s2_d.tag     = s1_q.tag;
   end

   if (LATENCY >= 3) begin : g_s2_reg
      s2_t s2_q;
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)     s2_q <= '0;
         else if (adv) s2_q <= s2_d;
      end
      assign s2_x = s2_q;
   end else begin : g_s2_comb
      assign s2_x = s2_d;
   end

   // S3: round and post-normalise
   logic          inc, lost;
   logic [MR-1:0] mant_r;
   s3_t           s3_d, s3_x;

   always_comb begin
      lost = s2_x.guard | s2_x.sticky;
      inc  = 1'b0;
      case (s2_x.rnd)
         RND_ZERO: inc = 1'b0;
         RND_PINF: inc = lost & !s2_x.sign;
         RND_NINF: inc = lost & s2_x.sign;
         RND_UP:   inc = s2_x.guard;
         RND_AWAY: inc = lost;
         default:  inc = s2_x.guard & (s2_x.sticky | s2_x.mant[0]);
      endcase
      mant_r       = {1'b0, s2_x.mant} + MR'(inc);
      s3_d.valid   = s2_x.valid;
      s3_d.sign    = s2_x.sign;
      s3_d.exp     = s2_x.exp + EW'(mant_r[MAN_W+1]);
      s3_d.frac    = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
      s3_d.inexact = lost;
      s3_d.is_nan  = s2_x.is_nan;
      s3_d.is_inf  = s2_x.is_inf;
      s3_d.is_zero = s2_x.is_zero;
      s3_d.rnd     = s2_x.rnd;
      s3_d.tag     = s2_x.tag;
   end

   if (LATENCY >= 4) begin : g_s3_reg
      s3_t s3_q;
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)     s3_q <= '0;
         else if (adv) s3_q <= s3_d;
      end
      assign s3_x = s3_q;
   end else begin : g_s3_comb
      assign s3_x = s3_d;
   end

   // S4: exceptions and pack
   logic                 ovf, unf, sat_dir;
   logic                 f_inexact, f_huge, f_tiny, f_nan, f_inf, f_zero;
   logic [EXP_W+MAN_W:0] z_d;

   always_comb begin
      // Directed modes saturate away from zero when rounding toward the result's sign
      sat_dir   = (s3_x.rnd == RND_AWAY) || (s3_x.rnd == RND_PINF && !s3_x.sign) ||
                  (s3_x.rnd == RND_NINF && s3_x.sign);
      ovf       = !s3_x.exp[EW-1] && (s3_x.exp > EXP_MAX);
      unf       = s3_x.exp[EW-1] || (s3_x.exp == '0);
      z_d       = {s3_x.sign, s3_x.exp[EXP_W-1:0], s3_x.frac};
      f_inexact = s3_x.inexact;
      f_huge    = 1'b0;
      f_tiny    = 1'b0;
      f_nan     = 1'b0;
      f_inf     = 1'b0;
      f_zero    = 1'b0;
      if (s3_x.is_nan) begin
         z_d       = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         f_inexact = 1'b0;
         f_nan     = 1'b1;
      end else if (s3_x.is_inf) begin
         z_d       = {s3_x.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         f_inexact = 1'b0;
         f_inf     = 1'b1;
      end else if (s3_x.is_zero) begin
         z_d       = {s3_x.sign, {(EXP_W+MAN_W){1'b0}}};
         f_inexact = 1'b0;
         f_zero    = 1'b1;
      end else if (ovf) begin
         f_huge    = 1'b1;
         f_inexact = 1'b1;
         if (sat_dir || s3_x.rnd == RND_NEAR || s3_x.rnd == RND_UP) begin
            z_d   = {s3_x.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            f_inf = 1'b1;
         end else begin
            z_d = {s3_x.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         end
      end else if (unf) begin
         f_tiny    = 1'b1;
         f_inexact = 1'b1;
         if (sat_dir) begin
            z_d = {s3_x.sign, {(EXP_W-1){1'b0}}, 1'b1, {MAN_W{1'b0}}};
         end else begin
            z_d    = {s3_x.sign, {(EXP_W+MAN_W){1'b0}}};
            f_zero = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         z         <= '0;
         status    <= '0;
         tag_out   <= '0;
      end else if (adv) begin
         out_valid <= s3_x.valid;
         if (s3_x.valid) begin
            z       <= z_d;
            status  <= {2'b00, f_inexact, f_huge, f_tiny, f_nan, f_inf, f_zero};
            tag_out <= s3_x.tag;
         end
      end
   end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe: single-precision LATENCY=3 instance plus a half-precision
// LATENCY=2 instance sharing clock and reset.
module tb_fp_mult_pipe;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic [31:0] a = '0, b = '0, z;
   logic [2:0]  rnd = '0;
   logic [3:0]  tag = '0, tag_out;
   logic [7:0]  status;

   logic        h_in_valid = 1'b0, h_in_ready, h_out_valid, h_out_ready = 1'b1;
   logic [15:0] h_a = '0, h_b = '0, h_z;
   logic [2:0]  h_rnd = '0;
   logic [3:0]  h_tag = '0, h_tag_out;
   logic [7:0]  h_status;

   int n_cmp = 0;
   int n_bad = 0;

   fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(3), .TAG_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .rnd(rnd),
      .tag(tag), .out_valid(out_valid), .out_ready(out_ready), .z(z), .status(status),
      .tag_out(tag_out)
   );

   fp_mult_pipe #(.EXP_W(5), .MAN_W(10), .LATENCY(2), .TAG_W(4)) dut_h (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b),
      .rnd(h_rnd), .tag(h_tag), .out_valid(h_out_valid), .out_ready(h_out_ready), .z(h_z),
      .status(h_status), .tag_out(h_tag_out)
   );

   // One beat into an idle pipe; returns the result and cycles from accept to out_valid.
   task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] ir,
                        input logic [3:0] it, output logic [31:0] oz, output logic [7:0] os,
                        output logic [3:0] ot, output int lat);
      @(negedge clk);
      a = ia; b = ib; rnd = ir; tag = it; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; rnd = 3'd1; tag = 4'd0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      oz = z; os = status; ot = tag_out;
   endtask

   task automatic issue_h(input logic [15:0] ia, input logic [15:0] ib, input logic [2:0] ir,
                          input logic [3:0] it, output logic [15:0] oz, output logic [7:0] os,
                          output logic [3:0] ot, output int lat);
      @(negedge clk);
      h_a = ia; h_b = ib; h_rnd = ir; h_tag = it; h_in_valid = 1'b1;
      @(posedge clk);
      #1 h_in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (h_out_valid) begin
            lat = i;
            break;
         end
      end
      oz = h_z; os = h_status; ot = h_tag_out;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (z !== 32'h0) begin n_bad++; $display("FAIL reset_z: got %h want 00000000", z); end
      n_cmp++; if (status !== 8'h0) begin n_bad++; $display("FAIL reset_status: got %h want 00", status); end
      n_cmp++; if (tag_out !== 4'h0) begin n_bad++; $display("FAIL reset_tag: got %h want 0", tag_out); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] oz; logic [7:0] os; logic [3:0] ot; int lat;
      issue(32'h3FC00000, 32'h40000000, 3'd0, 4'd5, oz, os, ot, lat);
      n_cmp++; if (oz !== 32'h40400000) begin n_bad++; $display("FAIL basic_z: got %h want 40400000", oz); end
      n_cmp++; if (os !== 8'h00) begin n_bad++; $display("FAIL basic_status: got %h want 00", os); end
      n_cmp++; if (ot !== 4'd5) begin n_bad++; $display("FAIL basic_tag: got %h want 5", ot); end
      n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL basic_latency: got %0d want 3", lat); end
   endtask

   task automatic test_rounding();
      logic [31:0] va [9], vb [9], vz [9];
      logic [2:0]  vr [9];
      logic [31:0] oz; logic [7:0] os; logic [3:0] ot; int lat;
      va = '{32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001,
             32'h3F800800, 32'h3F800800, 32'hBF800001, 32'hBF800001};
      vb = '{32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001,
             32'h3F800800, 32'h3F800800, 32'h3F800001, 32'h3F800001};
      vr = '{3'd0, 3'd2, 3'd3, 3'd5, 3'd7, 3'd0, 3'd4, 3'd3, 3'd2};
      vz = '{32'h3F800002, 32'h3F800003, 32'h3F800002, 32'h3F800003, 32'h3F800002,
             32'h3F801000, 32'h3F801001, 32'hBF800003, 32'hBF800002};
      for (int i = 0; i < 9; i++) begin
         issue(va[i], vb[i], vr[i], 4'(i), oz, os, ot, lat);
         n_cmp++;
         if (oz !== vz[i] || os !== 8'h20) begin
            n_bad++;
            $display("FAIL round_%0d: got z=%h st=%h want z=%h st=20", i, oz, os, vz[i]);
         end
      end
   endtask

   task automatic test_range();
      logic [31:0] va [11], vb [11], vz [11];
      logic [2:0]  vr [11];
      logic [7:0]  vs [11];
      logic [31:0] oz; logic [7:0] os; logic [3:0] ot; int lat;
      va = '{32'h7F000000, 32'h7F000000, 32'h7F000000, 32'hFF000000, 32'hFF000000,
             32'h00800000, 32'h00800000, 32'h80800000, 32'h80800000, 32'h7F000000,
             32'h00800000};
      vb = '{32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000,
             32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000, 32'h3F800000,
             32'h3F800000};
      vr = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd0, 3'd5, 3'd2, 3'd3, 3'd0, 3'd0};
      vz = '{32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 32'hFF7FFFFF, 32'hFF800000,
             32'h00000000, 32'h00800000, 32'h80000000, 32'h80800000, 32'h7F000000,
             32'h00800000};
      vs = '{8'h32, 8'h30, 8'h32, 8'h30, 8'h32, 8'h29, 8'h28, 8'h29, 8'h28, 8'h00, 8'h00};
      for (int i = 0; i < 11; i++) begin
         issue(va[i], vb[i], vr[i], 4'(i), oz, os, ot, lat);
         n_cmp++;
         if (oz !== vz[i] || os !== vs[i]) begin
            n_bad++;
            $display("FAIL range_%0d: got z=%h st=%h want z=%h st=%h", i, oz, os, vz[i], vs[i]);
         end
      end
   endtask

   task automatic test_specials();
      logic [31:0] va [8], vb [8], vz [8];
      logic [7:0]  vs [8];
      logic [31:0] oz; logic [7:0] os; logic [3:0] ot; int lat;
      va = '{32'h7F800000, 32'h00000000, 32'h7F800001, 32'hFFC00000, 32'h7F800000,
             32'h80000000, 32'h00000001, 32'h7F800000};
      vb = '{32'h00000000, 32'hFF800000, 32'h3F800000, 32'h00000000, 32'hBF800000,
             32'h3F800000, 32'h40000000, 32'h00000001};
      vz = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
             32'h80000000, 32'h00000000, 32'h7FC00000};
      vs = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h02, 8'h01, 8'h01, 8'h04};
      for (int i = 0; i < 8; i++) begin
         issue(va[i], vb[i], 3'd5, 4'(i), oz, os, ot, lat);
         n_cmp++;
         if (oz !== vz[i] || os !== vs[i]) begin
            n_bad++;
            $display("FAIL special_%0d: got z=%h st=%h want z=%h st=%h", i, oz, os, vz[i], vs[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ta [8], tb [8], tz [8];
      logic [2:0]  tr [8];
      int tx = 0;
      int rx = 0;
      ta = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h40000000, 32'h3F800001,
             32'h3F800001, 32'hC0000000, 32'h3F800800};
      tb = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h40000000, 32'h3F800001,
             32'h3F800001, 32'h40000000, 32'h3F800800};
      tr = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd1, 3'd5, 3'd0, 3'd4};
      tz = '{32'h40400000, 32'h3F800002, 32'h3F800003, 32'h40800000, 32'h3F800002,
             32'h3F800003, 32'hC0800000, 32'h3F801001};
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 6 && cyc < 11);
         in_valid  = (tx < 8);
         if (tx < 8) begin
            a = ta[tx]; b = tb[tx]; rnd = tr[tx]; tag = 4'(tx);
         end
         #1;
         if (!out_ready) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: cyc %0d got %b want 0", cyc, in_ready); end
         end
         if (out_valid) begin
            n_cmp++;
            if (rx >= 8) begin
               n_bad++;
               $display("FAIL stream_extra: got z=%h tag=%h want no beat", z, tag_out);
            end else if (z !== tz[rx] || tag_out !== 4'(rx)) begin
               n_bad++;
               $display("FAIL stream_beat_%0d: got z=%h tag=%h want z=%h tag=%h", rx, z, tag_out,
                        tz[rx], 4'(rx));
            end
            if (out_ready) rx++;
         end
         if (in_valid && in_ready) tx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_cmp++; if (rx != 8) begin n_bad++; $display("FAIL stream_count: got %0d retired want 8", rx); end
      n_cmp++; if (tx != 8) begin n_bad++; $display("FAIL stream_accepted: got %0d want 8", tx); end
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      @(negedge clk);
      a = 32'h3FC00000; b = 32'h40000000; rnd = 3'd0; tag = 4'd9; in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (z !== 32'h0 || status !== 8'h0 || tag_out !== 4'h0) begin
         n_bad++; $display("FAIL midrst_outputs: got z=%h st=%h tag=%h want all 0", z, status, tag_out);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midrst_stale: got %0d beats want 0", seen); end
   endtask

   task automatic test_half();
      logic [15:0] oz; logic [7:0] os; logic [3:0] ot; int lat;
      issue_h(16'h3C00, 16'h3C00, 3'd0, 4'd3, oz, os, ot, lat);
      n_cmp++; if (oz !== 16'h3C00) begin n_bad++; $display("FAIL half_one_z: got %h want 3C00", oz); end
      n_cmp++; if (os !== 8'h00) begin n_bad++; $display("FAIL half_one_status: got %h want 00", os); end
      n_cmp++; if (ot !== 4'd3) begin n_bad++; $display("FAIL half_one_tag: got %h want 3", ot); end
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL half_latency: got %0d want 2", lat); end
      issue_h(16'h7800, 16'h7800, 3'd0, 4'd4, oz, os, ot, lat);
      n_cmp++; if (oz !== 16'h7C00) begin n_bad++; $display("FAIL half_ovf_z: got %h want 7C00", oz); end
      n_cmp++; if (os !== 8'h32) begin n_bad++; $display("FAIL half_ovf_status: got %h want 32", os); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_range();
      test_specials();
      test_back_to_back();
      test_reset_midflight();
      test_half();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
